// File: rtl/irrigation_multizone_controller.sv
// Tank level counter, IDLE/FILL/WATER sequencer and round-robin service of ZONES irrigation zones.
// Define RAIN_HOLD_EN to add a rain input that suspends watering while it is high.

module irrigation_zone_lane (
  input  logic clock,
  input  logic reset_pulse,
  input  logic tick,
  input  logic sel,
  input  logic mode,
  output logic sprinkler,
  output logic dripper
);
  always_ff @(posedge clock or negedge reset_pulse) begin
    if (!reset_pulse) begin
      sprinkler <= 1'b0;
      dripper   <= 1'b0;
    end else if (tick) begin
      sprinkler <= sel & mode;
      dripper   <= sel & ~mode;
    end
  end
endmodule

module irrigation_multizone_controller #(
  parameter int ZONES     = 2,
  parameter int LEVEL_W   = 4,
  parameter int LEVEL_MAX = 7,
  parameter int LOW_MARK  = 1,
  parameter int DWELL     = 4,
  localparam int ZW       = (ZONES > 1) ? $clog2(ZONES) : 1
) (
  input  logic               clock,
  input  logic               reset_pulse,
  input  logic               tick,
  input  logic [ZONES-1:0]   zone_enable,
  input  logic [ZONES-1:0]   zone_mode,
`ifdef RAIN_HOLD_EN
  input  logic               rain,
`endif
  output logic [1:0]         state,
  output logic               filling,
  output logic               watering,
  output logic [ZONES-1:0]   sprinkler,
  output logic [ZONES-1:0]   dripper,
  output logic [ZW-1:0]      active_zone,
  output logic [LEVEL_W-1:0] water_level
);
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FILL  = 2'b01,
    S_WATER = 2'b10
  } state_t;

  state_t             st_q, st_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [ZW-1:0]      zone_q, zone_d;
  logic [ZW-1:0]      ptr_q, ptr_d;
  logic [DW-1:0]      dwell_q, dwell_d;
  logic               mode_q, mode_d;
  logic               filling_q, watering_q;
  logic               rain_hold;

`ifdef RAIN_HOLD_EN
  assign rain_hold = rain;
`else
  assign rain_hold = 1'b0;
`endif

  // Round-robin pick: rotate requests so the pointer sits at bit 0, take the lowest set bit.
  logic [ZONES-1:0] en_rot;
  logic [ZW-1:0]    pick_off, pick_zone;
  logic [ZW:0]      pick_sum;
  logic             pick_found, pick_mode;

  always_comb begin
    en_rot     = ZONES'({zone_enable, zone_enable} >> ptr_q);
    pick_found = 1'b0;
    pick_off   = '0;
    for (int j = ZONES - 1; j >= 0; j--) begin
      if (en_rot[j]) begin
        pick_found = 1'b1;
        pick_off   = ZW'(j);
      end
    end
    pick_sum = {1'b0, ptr_q} + {1'b0, pick_off};
    if (pick_sum >= (ZW+1)'(ZONES)) pick_sum = pick_sum - (ZW+1)'(ZONES);
    pick_zone = pick_sum[ZW-1:0];
    pick_mode = |(zone_mode & (ZONES'(1) << pick_zone));
  end

  // One watering tick; the IDLE->WATER entry tick is itself the first watering tick.
  logic               entering, w_mode, w_en, w_low, w_end;
  logic [ZW-1:0]      w_zone, w_ptr_inc;
  logic [DW-1:0]      w_dwell;
  logic [LEVEL_W-1:0] w_cost, w_level;

  always_comb begin
    entering  = (st_q == S_IDLE);
    w_zone    = entering ? pick_zone : zone_q;
    w_mode    = entering ? pick_mode : mode_q;
    w_dwell   = entering ? '0 : dwell_q;
    w_en      = entering ? 1'b1 : |(zone_enable & (ZONES'(1) << zone_q));
    w_cost    = w_mode ? LEVEL_W'(2) : LEVEL_W'(1);
    w_level   = (level_q > w_cost) ? level_q - w_cost : '0;
    w_low     = (w_level <= LEVEL_W'(LOW_MARK));
    w_end     = !w_en || (w_dwell == DW'(DWELL - 1));
    w_ptr_inc = (w_zone == ZW'(ZONES - 1)) ? '0 : w_zone + ZW'(1);
  end

  always_comb begin
    st_d    = st_q;
    level_d = level_q;
    zone_d  = zone_q;
    ptr_d   = ptr_q;
    dwell_d = dwell_q;
    mode_d  = mode_q;
    case (st_q)
      S_IDLE: begin
        if (level_q <= LEVEL_W'(LOW_MARK)) begin
          st_d = S_FILL;
        end else if (pick_found && !rain_hold) begin
          zone_d  = pick_zone;
          ptr_d   = pick_zone;
          mode_d  = pick_mode;
          level_d = w_level;
          dwell_d = '0;
          if (w_low) begin
            st_d = S_FILL;
          end else if (w_end) begin
            st_d  = S_IDLE;
            ptr_d = w_ptr_inc;
          end else begin
            st_d    = S_WATER;
            dwell_d = w_dwell + DW'(1);
          end
        end
      end
      S_FILL: begin
        level_d = (level_q >= LEVEL_W'(LEVEL_MAX - 1)) ? LEVEL_W'(LEVEL_MAX)
                                                       : level_q + LEVEL_W'(1);
        if (level_d == LEVEL_W'(LEVEL_MAX)) st_d = S_IDLE;
      end
      S_WATER: begin
        if (rain_hold) begin
          st_d    = S_IDLE;
          ptr_d   = w_ptr_inc;
          dwell_d = '0;
        end else begin
          level_d = w_level;
          if (w_low) begin
            // Pointer stays on this zone so it resumes with a fresh dwell after refill.
            st_d    = S_FILL;
            dwell_d = '0;
          end else if (w_end) begin
            st_d    = S_IDLE;
            ptr_d   = w_ptr_inc;
            dwell_d = '0;
          end else begin
            dwell_d = w_dwell + DW'(1);
          end
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_pulse) begin
    if (!reset_pulse) begin
      st_q       <= S_IDLE;
      level_q    <= LEVEL_W'(LEVEL_MAX);
      zone_q     <= '0;
      ptr_q      <= '0;
      dwell_q    <= '0;
      mode_q     <= 1'b0;
      filling_q  <= 1'b0;
      watering_q <= 1'b0;
    end else if (tick) begin
      st_q       <= st_d;
      level_q    <= level_d;
      zone_q     <= zone_d;
      ptr_q      <= ptr_d;
      dwell_q    <= dwell_d;
      mode_q     <= mode_d;
      filling_q  <= (st_d == S_FILL);
      watering_q <= (st_d == S_WATER);
    end
  end

  for (genvar g = 0; g < ZONES; g++) begin : g_lane
    irrigation_zone_lane u_lane (
      .clock      (clock),
      .reset_pulse(reset_pulse),
      .tick       (tick),
      .sel        ((st_d == S_WATER) && (zone_d == ZW'(g))),
      .mode       (mode_d),
      .sprinkler  (sprinkler[g]),
      .dripper    (dripper[g])
    );
  end

  assign state       = st_q;
  assign filling     = filling_q;
  assign watering    = watering_q;
  assign active_zone = zone_q;
  assign water_level = level_q;
endmodule

// File: tb/tb_irrigation_multizone_controller.sv
// Directed table plus randomized run against an integer reference model of the irrigation controller.

module tb_irrigation_multizone_controller;
  localparam int NZ   = 2;
  localparam int LMAX = 7;
  localparam int LOW  = 1;
  localparam int DWL  = 4;

  logic          clock = 1'b0;
  logic          reset_pulse;
  logic          tick;
  logic [NZ-1:0] zone_enable, zone_mode;
  logic [1:0]    state;
  logic          filling, watering;
  logic [NZ-1:0] sprinkler, dripper;
  logic          active_zone;
  logic [3:0]    water_level;

  int vectors = 0;
  int miscompares = 0;

  irrigation_multizone_controller dut (
    .clock      (clock),
    .reset_pulse(reset_pulse),
    .tick       (tick),
    .zone_enable(zone_enable),
    .zone_mode  (zone_mode),
    .state      (state),
    .filling    (filling),
    .watering   (watering),
    .sprinkler  (sprinkler),
    .dripper    (dripper),
    .active_zone(active_zone),
    .water_level(water_level)
  );

  always #5 clock = ~clock;

  // Reference model: 0 idle, 1 fill, 2 water; turn = ticks watered in this turn.
  int m_state, m_level, m_zone, m_next, m_turn, m_mode;

  task automatic model_reset();
    m_state = 0; m_level = LMAX; m_zone = 0; m_next = 0; m_turn = 0; m_mode = 0;
  endtask

  function automatic bit bit_at(input logic [NZ-1:0] v, input int i);
    bit r = 1'b0;
    for (int b = 0; b < NZ; b++) if (b == i) r = v[b];
    return r;
  endfunction

  task automatic model_water(input bit still_enabled);
    m_level = m_level - (m_mode != 0 ? 2 : 1);
    if (m_level < 0) m_level = 0;
    m_turn++;
    if (m_level <= LOW) begin
      m_state = 1; m_turn = 0; m_next = m_zone;
    end else if (!still_enabled || m_turn == DWL) begin
      m_state = 0; m_turn = 0; m_next = (m_zone + 1) % NZ;
    end else begin
      m_state = 2;
    end
  endtask

  task automatic model_tick(input logic [NZ-1:0] en, input logic [NZ-1:0] md);
    int pick;
    case (m_state)
      0: begin
        if (m_level <= LOW) m_state = 1;
        else begin
          pick = -1;
          for (int k = 0; k < NZ; k++)
            if (pick < 0 && bit_at(en, (m_next + k) % NZ)) pick = (m_next + k) % NZ;
          if (pick >= 0) begin
            m_zone = pick; m_next = pick; m_mode = bit_at(md, pick); m_turn = 0;
            model_water(1'b1);
          end
        end
      end
      1: begin
        m_level = (m_level + 1 > LMAX) ? LMAX : m_level + 1;
        if (m_level == LMAX) m_state = 0;
      end
      default: model_water(bit_at(en, m_zone));
    endcase
  endtask

  function automatic logic [12:0] pk(input logic [1:0] st, input int lvl, input int zn,
                                     input logic [1:0] spr, input logic [1:0] drp);
    return {st, st == 2'b01, st == 2'b10, spr, drp, 1'(zn), 4'(lvl)};
  endfunction

  function automatic logic [12:0] model_pk();
    logic [1:0] oh = 2'(1 << m_zone);
    bit w = (m_state == 2);
    return pk(2'(m_state), m_level, m_zone, (w && m_mode != 0) ? oh : 2'b00,
              (w && m_mode == 0) ? oh : 2'b00);
  endfunction

  function automatic logic [12:0] dut_pk();
    return {state, filling, watering, sprinkler, dripper, active_zone, water_level};
  endfunction

  task automatic check(input string nm, input logic [12:0] exp);
    logic [12:0] got = dut_pk();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got {st,fill,wat,spr,drp,zone,lvl}=%b expected %b", nm, got, exp);
    end
  endtask

  typedef struct {
    bit         tk;
    logic [1:0] en, md, st;
    int         lvl, zn;
    logic [1:0] spr, drp;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input bit tk, input logic [1:0] en, input logic [1:0] md,
                     input logic [1:0] st, input int lvl, input int zn,
                     input logic [1:0] spr, input logic [1:0] drp);
    vec_t v;
    v.tk = tk; v.en = en; v.md = md; v.st = st; v.lvl = lvl; v.zn = zn; v.spr = spr; v.drp = drp;
    tbl.push_back(v);
  endtask

  initial begin
    // Sprinkler zone0 drains 7->5->3->1, refill, then two dripper zones round-robin.
    row(1, 2'b01, 2'b01, 2'b10, 5, 0, 2'b01, 2'b00);
    row(1, 2'b01, 2'b01, 2'b10, 3, 0, 2'b01, 2'b00);
    row(1, 2'b01, 2'b01, 2'b01, 1, 0, 2'b00, 2'b00);
    row(0, 2'b11, 2'b11, 2'b01, 1, 0, 2'b00, 2'b00);
    for (int l = 2; l <= 6; l++) row(1, 2'b01, 2'b01, 2'b01, l, 0, 2'b00, 2'b00);
    row(1, 2'b01, 2'b01, 2'b00, 7, 0, 2'b00, 2'b00);
    row(1, 2'b11, 2'b00, 2'b10, 6, 0, 2'b00, 2'b01);
    row(1, 2'b11, 2'b00, 2'b10, 5, 0, 2'b00, 2'b01);
    row(1, 2'b11, 2'b00, 2'b10, 4, 0, 2'b00, 2'b01);
    row(1, 2'b11, 2'b00, 2'b00, 3, 0, 2'b00, 2'b00);
    row(1, 2'b11, 2'b00, 2'b10, 2, 1, 2'b00, 2'b10);
    row(1, 2'b11, 2'b00, 2'b01, 1, 1, 2'b00, 2'b00);
    for (int l = 2; l <= 6; l++) row(1, 2'b11, 2'b00, 2'b01, l, 1, 2'b00, 2'b00);
    row(1, 2'b11, 2'b00, 2'b00, 7, 1, 2'b00, 2'b00);
    row(1, 2'b11, 2'b00, 2'b10, 6, 1, 2'b00, 2'b10);  // zone1 resumes after refill
    row(1, 2'b01, 2'b00, 2'b00, 5, 1, 2'b00, 2'b00);  // zone1 dropped mid-dwell
    row(1, 2'b11, 2'b10, 2'b10, 4, 0, 2'b00, 2'b01);  // fairness: zone0 next
    row(1, 2'b11, 2'b11, 2'b10, 3, 0, 2'b00, 2'b01);  // mode change ignored
    row(1, 2'b11, 2'b11, 2'b10, 2, 0, 2'b00, 2'b01);
    row(1, 2'b10, 2'b11, 2'b01, 1, 0, 2'b00, 2'b00);  // low level beats disable

    reset_pulse = 1'b0; tick = 1'b0; zone_enable = '0; zone_mode = '0;
    @(negedge clock);
    check("reset", pk(2'b00, 7, 0, 2'b00, 2'b00));
    reset_pulse = 1'b1;

    foreach (tbl[i]) begin
      tick = tbl[i].tk; zone_enable = tbl[i].en; zone_mode = tbl[i].md;
      @(negedge clock);
      tick = 1'b0;
      check($sformatf("table[%0d]", i), pk(tbl[i].st, tbl[i].lvl, tbl[i].zn, tbl[i].spr, tbl[i].drp));
    end

    // No tick for 100 cycles while requests change: everything holds.
    for (int c = 1; c <= 100; c++) begin
      zone_enable = NZ'($urandom); zone_mode = NZ'($urandom);
      @(negedge clock);
      if (c % 10 == 0) check("hold", pk(2'b01, 1, 0, 2'b00, 2'b00));
    end

    zone_enable = 2'b00;
    for (int c = 0; c < 6; c++) begin
      tick = 1'b1; @(negedge clock); tick = 1'b0;
    end
    check("refill_done", pk(2'b00, 7, 0, 2'b00, 2'b00));
    zone_enable = 2'b01; zone_mode = 2'b01; tick = 1'b1;
    @(negedge clock);
    tick = 1'b0;
    check("water_again", pk(2'b10, 5, 0, 2'b01, 2'b00));
    #2 reset_pulse = 1'b0;
    #1 check("async_reset", pk(2'b00, 7, 0, 2'b00, 2'b00));
    @(negedge clock);
    reset_pulse = 1'b1;

    model_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset_pulse = 1'b0;
        #1 model_reset();
        check("rand_reset", model_pk());
        @(negedge clock);
        reset_pulse = 1'b1;
      end
      tick = ($urandom_range(0, 2) != 0);
      zone_enable = ($urandom_range(0, 5) == 0) ? 2'b00 : NZ'($urandom);
      zone_mode = NZ'($urandom);
      if (tick) model_tick(zone_enable, zone_mode);
      @(negedge clock);
      check("random", model_pk());
    end
    tick = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
